// File: rtl/imu_event_capture.sv
// imu_event_capture
// Turns each above-threshold excursion reported by the IMU threshold detector
// into one event record {start timestamp, duration, signed peak} and buffers
// the records in a first-word-fall-through FIFO for the host/telemetry side.
//
// Ports
//   clk, rst_n     clock; synchronous active-low reset
//   en             capture enable, gates only the start of new events
//   sample_in      signed sample stream (same stream that feeds the detector)
//   event_flag     registered detector flag, aligned with the delayed sample
//   rec_ready      consumer ready
//   clear_ovf      single-cycle pulse that zeroes overflow_cnt
//   rec_valid      FIFO head valid (FIFO not empty)
//   rec_ts/dur/peak head record fields, forced to zero while rec_valid=0
//   fifo_count     records currently stored
//   overflow_cnt   records dropped on a full FIFO, saturates at 255
//   dbg_state      FSM state: 0=IDLE 1=ACTIVE 2=COMMIT
//
// Handshake: a record is transferred on every rising clk edge where
// rec_valid && rec_ready. rec_valid never depends on rec_ready, and the head
// record stays stable until it is transferred.
module imu_event_capture #(
  parameter int WIDTH     = 16,
  parameter int TS_WIDTH  = 32,
  parameter int DUR_WIDTH = 16,
  parameter int DEPTH     = 8,
  parameter int MIN_LEN   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [WIDTH-1:0]         sample_in,
  input  logic                     event_flag,
  input  logic                     rec_ready,
  input  logic                     clear_ovf,
  output logic                     rec_valid,
  output logic [TS_WIDTH-1:0]      rec_ts,
  output logic [DUR_WIDTH-1:0]     rec_dur,
  output logic [WIDTH-1:0]         rec_peak,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               overflow_cnt,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]          FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [DUR_WIDTH-1:0] DUR_MAX   = '1;
  localparam logic [DUR_WIDTH-1:0] MIN_LEN_W = DUR_WIDTH'(MIN_LEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] sample_d_q;
  logic signed [WIDTH-1:0] peak_q, peak_d;
  logic [TS_WIDTH-1:0]     ts_q;
  logic [TS_WIDTH-1:0]     start_ts_q, start_ts_d;
  logic [DUR_WIDTH-1:0]    dur_q, dur_d;

  // FIFO storage and bookkeeping
  logic [TS_WIDTH-1:0]  ts_mem   [DEPTH];
  logic [DUR_WIDTH-1:0] dur_mem  [DEPTH];
  logic [WIDTH-1:0]     peak_mem [DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          cnt_q, cnt_d;
  logic [7:0]           ovf_q;
  logic                 full, pop, push, drop;

  assign full = (cnt_q == FULL_CNT);
  assign pop  = rec_valid && rec_ready;
  // A pop in the commit cycle frees the slot the new record needs.
  assign push = (state_q == S_COMMIT) && (!full || pop);
  assign drop = (state_q == S_COMMIT) && full && !pop;

  // State register and per-cycle datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sample_d_q <= '0;
      ts_q       <= '0;
      start_ts_q <= '0;
      dur_q      <= '0;
      peak_q     <= '0;
    end else begin
      state_q    <= state_d;
      sample_d_q <= sample_in;
      ts_q       <= ts_q + 1'b1;
      start_ts_q <= start_ts_d;
      dur_q      <= dur_d;
      peak_q     <= peak_d;
    end
  end

  // Next-state and event accumulation
  always_comb begin
    state_d    = state_q;
    start_ts_d = start_ts_q;
    dur_d      = dur_q;
    peak_d     = peak_q;
    case (state_q)
      S_IDLE: begin
        if (en && event_flag) begin
          start_ts_d = ts_q;
          dur_d      = DUR_WIDTH'(1);
          peak_d     = sample_d_q;
          state_d    = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // en is deliberately ignored here: a started event always completes.
        if (event_flag) begin
          if (dur_q != DUR_MAX) dur_d = dur_q + 1'b1;
          if (sample_d_q > peak_q) peak_d = sample_d_q;
        end else if (dur_q >= MIN_LEN_W) begin
          state_d = S_COMMIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FIFO storage (contents need no reset; outputs are gated by rec_valid)
  always_ff @(posedge clk) begin
    if (push) begin
      ts_mem[wr_q]   <= start_ts_q;
      dur_mem[wr_q]  <= dur_q;
      peak_mem[wr_q] <= peak_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      // Clear takes priority over a simultaneous drop.
      if (clear_ovf)                 ovf_q <= '0;
      else if (drop && ovf_q != '1)  ovf_q <= ovf_q + 1'b1;
    end
  end

  assign rec_valid    = (cnt_q != '0);
  assign rec_ts       = rec_valid ? ts_mem[rd_q]   : '0;
  assign rec_dur      = rec_valid ? dur_mem[rd_q]  : '0;
  assign rec_peak     = rec_valid ? peak_mem[rd_q] : '0;
  assign fifo_count   = cnt_q;
  assign overflow_cnt = ovf_q;
  assign dbg_state    = state_q;

endmodule
